// File: rtl/mult_share_arbiter.sv
// Shares one signed WIDTH x WIDTH multiplier among NUM_REQ valid/ready requesters, one op in flight.
// Define MULT_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; default build is round-robin.
//
//   state | meaning
//   IDLE  | arbitrating, req_ready driven combinationally from req_valid
//   WAIT  | operands held on mul_a/mul_b, counting down the multiplier latency
//   RESP  | one-cycle rsp_valid strobe to the owner, rsp_p holds the product
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_p,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]         rsp_p,
    output logic                       busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   winner;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
`ifndef MULT_ARB_FIXED_PRIO_EN
    logic [PW-1:0]   rr_ptr;
`endif

    // Round-robin: first pass takes indices above rr_ptr, second pass wraps to the bottom.
    always_comb begin
        found  = 1'b0;
        winner = '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (PW'(i) > rr_ptr)) begin
                found  = 1'b1;
                winner = PW'(i);
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = PW'(i);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst so no grant is ever shown while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst && (state == IDLE) && found) begin
            req_ready = NUM_REQ'(1) << winner;
        end
    end

    assign busy = (state == WAIT) || (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            rr_ptr    <= PW'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_a  <= sel_a;
                        mul_b  <= sel_b;
                        owner  <= winner;
                        cnt    <= CW'(MUL_LAT);
`ifndef MULT_ARB_FIXED_PRIO_EN
                        rr_ptr <= winner;
`endif
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NUM_REQ=4, WIDTH=32, MUL_LAT=2) with a one-stage multiplier model.
module tb_mult_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [63:0]  mul_p;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_p;
    logic         busy;

    int tests = 0;
    int fails = 0;

    mult_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product registered once after the operands: valid one edge before the DUT samples it.
    always @(posedge clk) begin
        mul_p <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    end

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
    endtask

    task automatic wait_ready(output logic [3:0] g, output int n);
        g = '0;
        n = -1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready != 4'b0) begin
                g = req_ready;
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output logic [3:0] v, output logic [63:0] p, output int n);
        v = '0;
        p = '0;
        n = -1;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid != 4'b0) begin
                v = rsp_valid;
                p = rsp_p;
                n = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh == (4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready got=%h want=0", req_ready); end
        tests++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL reset_rsp_valid got=%h want=0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if (mul_a !== 32'h0) begin fails++; $display("FAIL reset_mul_a got=%h want=0", mul_a); end
        tests++; if (mul_b !== 32'h0) begin fails++; $display("FAIL reset_mul_b got=%h want=0", mul_b); end
        tests++; if (rsp_p !== 64'h0) begin fails++; $display("FAIL reset_rsp_p got=%h want=0", rsp_p); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0]  v;
        logic [63:0] p;
        int          n;
        set_op(0, 32'd20, 32'd75);
        req_valid = 4'b0001;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got=%b want=0001", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b want=1", busy); end
        tests++; if (mul_a !== 32'd20 || mul_b !== 32'd75) begin fails++; $display("FAIL single_operands got=%h,%h want=14,4b", mul_a, mul_b); end
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL single_ready_wait got=%b want=0000", req_ready); end
        wait_rsp(v, p, n);
        tests++; if (n !== MUL_LAT) begin fails++; $display("FAIL single_latency got=%0d want=%0d", n, MUL_LAT); end
        tests++; if (v !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid got=%b want=0001", v); end
        tests++; if (p !== 64'd1500) begin fails++; $display("FAIL single_rsp_p got=%0d want=1500", p); end
        @(negedge clk);
        tests++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_strobe_end got=%b,%b want=0000,0", rsp_valid, busy); end
        tests++; if (rsp_p !== 64'd1500) begin fails++; $display("FAIL single_rsp_hold got=%0d want=1500", rsp_p); end
    endtask

    task automatic test_all_four();
        logic [63:0] ep [4];
        logic [3:0]  g, v, eg;
        logic [63:0] p;
        int          n, gi;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ep[0] = 64'd2;
        ep[1] = 64'h0000_0000_0000_0810;
        ep[2] = 64'hFFFF_FFFF_FFFF_FFF4;
        ep[3] = 64'h3FFF_FFFF_0000_0001;
        set_op(0, 32'd1, 32'd2);
        set_op(1, 32'hFFFF_FFD5, 32'hFFFF_FFD0);
        set_op(2, 32'd3, 32'hFFFF_FFFC);
        set_op(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) begin
            eg = 4'b0001 << k;
            wait_ready(g, n);
            gi = idx_of(g);
            tests++; if (g !== eg) begin fails++; $display("FAIL all4_grant%0d got=%b want=%b", k, g, eg); end
            @(posedge clk);
            @(negedge clk);
            if (gi >= 0) req_valid[gi] = 1'b0;
            wait_rsp(v, p, n);
            tests++; if (v !== eg) begin fails++; $display("FAIL all4_rsp_valid%0d got=%b want=%b", k, v, eg); end
            tests++; if (p !== ep[k]) begin fails++; $display("FAIL all4_rsp_p%0d got=%h want=%h", k, p, ep[k]); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_hold_two();
        logic [3:0]  exp_g [4];
        logic [3:0]  g, v;
        logic [63:0] p, ep;
        int          n;
`ifdef MULT_ARB_FIXED_PRIO_EN
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
`else
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
`endif
        set_op(0, 32'd5, 32'd6);
        set_op(2, 32'hFFFF_FFFE, 32'd9);
        req_valid = 4'b0101;
        #1;
        for (int k = 0; k < 4; k++) begin
            ep = (exp_g[k] == 4'b0001) ? 64'd30 : 64'hFFFF_FFFF_FFFF_FFEE;
            wait_ready(g, n);
            tests++; if (g !== exp_g[k]) begin fails++; $display("FAIL hold_grant%0d got=%b want=%b", k, g, exp_g[k]); end
            @(posedge clk);
            @(negedge clk);
            wait_rsp(v, p, n);
            tests++; if (v !== exp_g[k] || p !== ep) begin fails++; $display("FAIL hold_rsp%0d got=%b/%h want=%b/%h", k, v, p, exp_g[k], ep); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0]  g, v;
        logic [63:0] p;
        int          n, bad;
        set_op(3, 32'd23, 32'hFFFF_FFF1);
        req_valid = 4'b1000;
        #1;
        wait_ready(g, n);
        tests++; if (g !== 4'b1000) begin fails++; $display("FAIL rstmid_grant got=%b want=1000", g); end
        @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy got=%b want=1", busy); end
        rst = 1'b0;
        #1;
        tests++;
        if ({req_ready, rsp_valid, busy, mul_a, mul_b, rsp_p} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs got=%b,%b,%b,%h,%h,%h want=all 0", req_ready, rsp_valid, busy, mul_a, mul_b, rsp_p);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0 || busy || req_ready != 4'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_quiet got=%0d want=0", bad); end
        rst = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rstmid_reissue_ready got=%b want=1000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(v, p, n);
        tests++; if (v !== 4'b1000) begin fails++; $display("FAIL rstmid_rsp_valid got=%b want=1000", v); end
        tests++; if (p !== 64'hFFFF_FFFF_FFFF_FEA7) begin fails++; $display("FAIL rstmid_rsp_p got=%h want=fffffffffffffea7", p); end
        @(negedge clk);
    endtask

    task automatic test_zero_operand();
        logic [31:0] bv [2];
        logic [63:0] ep [2];
        logic [3:0]  gv, stray;
        logic [63:0] gp;
        int          busy_cnt;
        bv[0] = 32'd0;  ep[0] = 64'd0;
        bv[1] = 32'd1;  ep[1] = 64'h0A;
        for (int k = 0; k < 2; k++) begin
            set_op(2, 32'h0000_000A, bv[k]);
            req_valid = 4'b0100;
            #1;
            tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL zero_ready%0d got=%b want=0100", k, req_ready); end
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            busy_cnt = 0;
            stray = '0;
            gv = '0;
            gp = 64'hDEAD;
            for (int i = 0; i < 7; i++) begin
                if (busy) busy_cnt++;
                stray |= req_ready;
                if (rsp_valid != 4'b0) begin
                    gv = rsp_valid;
                    gp = rsp_p;
                end
                @(negedge clk);
            end
            tests++; if (busy_cnt !== 3) begin fails++; $display("FAIL zero_busy_cycles%0d got=%0d want=3", k, busy_cnt); end
            tests++; if (stray !== 4'b0) begin fails++; $display("FAIL zero_stray_ready%0d got=%b want=0000", k, stray); end
            tests++; if (gv !== 4'b0100 || gp !== ep[k]) begin fails++; $display("FAIL zero_rsp%0d got=%b/%h want=0100/%h", k, gv, gp, ep[k]); end
            tests++; if (mul_a !== 32'h0A || mul_b !== bv[k]) begin fails++; $display("FAIL zero_operand_hold%0d got=%h,%h want=a,%h", k, mul_a, mul_b, bv[k]); end
        end
    endtask

    task automatic test_idle();
        logic [3:0]  v;
        logic [63:0] p;
        int          n, bad;
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({req_ready, rsp_valid, busy, mul_a, mul_b, rsp_p} != '0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle_outputs got=%0d nonzero cycles want=0", bad); end
        set_op(1, 32'd3, 32'd4);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL idle_ready got=%b want=0010", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(v, p, n);
        tests++; if (v !== 4'b0010 || p !== 64'd12) begin fails++; $display("FAIL idle_rsp got=%b/%0d want=0010/12", v, p); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_hold_two();
        test_reset_mid();
        test_zero_operand();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
